ram_port_rr_arbiter: RTL and testbench

- Shares one single-port 2KB RAM (sync read, 1-cycle latency) between two requesters, A and B.
- Arbitration is round-robin. Each access is sequenced through a fixed 4-cycle FSM.
- Per-requester partitions are enforced: A owns the low half, B owns the high half. Out-of-partition accesses are never issued to the RAM; they are acked with an error flag.
- Sits between the two client engines and the RAM macro in the memory subsystem.

---
 rtl/ram_arb_pkg.sv | 21 ++
 rtl/rr_arb2.sv | 23 ++
 rtl/ram_port_rr_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_ram_port_rr_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and default sizing for the two-requester RAM port arbiter.
package ram_arb_pkg;

  localparam int unsigned DATA_W        = 8;
  localparam int unsigned ADDR_W        = 11;
  localparam int unsigned PART_BOUNDARY = 1024;
  localparam int unsigned DEPTH         = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RDWAIT,
    DONE
  } state_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker: a lone requester wins, a tie goes
// to whichever requester was not granted last.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    last_gnt,
  output logic       gnt_valid,
  output req_id_t    gnt_id
);

  // Pick the winner from the current request pair and the previous grant.
  always_comb begin
    gnt_valid = |req;
    gnt_id    = REQ_A;
    case (req)
      2'b10:   gnt_id = REQ_B;
      2'b11:   gnt_id = (last_gnt == REQ_A) ? REQ_B : REQ_A;
      default: gnt_id = REQ_A;
    endcase
  end

endmodule

// File: rtl/ram_port_rr_arbiter.sv
// Shares one single-port sync-read RAM between requesters A and B. Each access
// runs a fixed IDLE -> ACCESS -> RDWAIT -> DONE sequence; out-of-partition
// accesses never reach the RAM and are acked with an error flag.
module ram_port_rr_arbiter #(
  parameter int unsigned DATA_W        = ram_arb_pkg::DATA_W,
  parameter int unsigned ADDR_W        = ram_arb_pkg::ADDR_W,
  parameter int unsigned PART_BOUNDARY = ram_arb_pkg::PART_BOUNDARY,
  parameter bit          PROT_EN       = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_a,
  input  logic              req_b,
  input  logic              we_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              ack_a,
  output logic              ack_b,
  output logic              err_a,
  output logic              err_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  import ram_arb_pkg::*;

  state_t            r_state, w_state_nxt;
  req_id_t           r_last_gnt, r_id, w_gnt_id;
  logic              w_gnt_valid;
  logic              r_we, r_err;

  logic              w_win_we, w_win_err, w_part_err, w_oob;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_wdata;
  logic [31:0]       w_addr_u;

  logic              r_mem_en, r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_ack_a, r_ack_b, r_err_a, r_err_b, r_busy;
  logic [DATA_W-1:0] r_rdata_a, r_rdata_b;

  logic              w_mem_en_nxt, w_mem_we_nxt;
  logic              w_ack_a_nxt, w_ack_b_nxt, w_err_a_nxt, w_err_b_nxt;
  logic [DATA_W-1:0] w_rdata_nxt;

  rr_arb2 u_rr_arb2 (
    .req       ({req_b, req_a}),
    .last_gnt  (r_last_gnt),
    .gnt_valid (w_gnt_valid),
    .gnt_id    (w_gnt_id)
  );

  // Select the winner's command and decide whether it may touch the RAM.
  // Addresses beyond the physical RAM are rejected even with protection off.
  always_comb begin
    w_win_we    = (w_gnt_id == REQ_B) ? we_b    : we_a;
    w_win_addr  = (w_gnt_id == REQ_B) ? addr_b  : addr_a;
    w_win_wdata = (w_gnt_id == REQ_B) ? wdata_b : wdata_a;
    w_addr_u    = 32'(w_win_addr);
    w_oob       = (w_addr_u >= DEPTH);
    w_part_err  = 1'b0;
    if (PROT_EN) begin
      if (w_gnt_id == REQ_A) w_part_err = (w_addr_u >= PART_BOUNDARY);
      else                   w_part_err = (w_addr_u <  PART_BOUNDARY);
    end
    w_win_err = w_oob | w_part_err;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state: a grant starts the fixed four-cycle sequence.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_gnt_valid) w_state_nxt = ACCESS;
      ACCESS:  w_state_nxt = RDWAIT;
      RDWAIT:  w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output decode: next values for the registered RAM strobes and responses.
  always_comb begin
    w_mem_en_nxt = 1'b0;
    w_mem_we_nxt = 1'b0;
    w_ack_a_nxt  = 1'b0;
    w_ack_b_nxt  = 1'b0;
    w_err_a_nxt  = 1'b0;
    w_err_b_nxt  = 1'b0;
    w_rdata_nxt  = '0;
    case (r_state)
      IDLE: begin
        if (w_gnt_valid && !w_win_err) begin
          w_mem_en_nxt = 1'b1;
          w_mem_we_nxt = w_win_we;
        end
      end
      RDWAIT: begin
        w_ack_a_nxt = (r_id == REQ_A);
        w_ack_b_nxt = (r_id == REQ_B);
        w_err_a_nxt = (r_id == REQ_A) && r_err;
        w_err_b_nxt = (r_id == REQ_B) && r_err;
        if (!r_we && !r_err) w_rdata_nxt = mem_rdata;
      end
      default: ;
    endcase
  end

  // Latch the granted command; RAM address/data hold their value between grants.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_gnt  <= REQ_B;
      r_id        <= REQ_A;
      r_we        <= 1'b0;
      r_err       <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (r_state == IDLE && w_gnt_valid) begin
      r_last_gnt  <= w_gnt_id;
      r_id        <= w_gnt_id;
      r_we        <= w_win_we;
      r_err       <= w_win_err;
      r_mem_addr  <= w_win_addr;
      r_mem_wdata <= w_win_wdata;
    end
  end

  // Register RAM strobes, responses and busy so no output is combinational.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_en  <= 1'b0;
      r_mem_we  <= 1'b0;
      r_ack_a   <= 1'b0;
      r_ack_b   <= 1'b0;
      r_err_a   <= 1'b0;
      r_err_b   <= 1'b0;
      r_rdata_a <= '0;
      r_rdata_b <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_mem_en  <= w_mem_en_nxt;
      r_mem_we  <= w_mem_we_nxt;
      r_ack_a   <= w_ack_a_nxt;
      r_ack_b   <= w_ack_b_nxt;
      r_err_a   <= w_err_a_nxt;
      r_err_b   <= w_err_b_nxt;
      r_rdata_a <= w_ack_a_nxt ? w_rdata_nxt : '0;
      r_rdata_b <= w_ack_b_nxt ? w_rdata_nxt : '0;
      r_busy    <= (w_state_nxt != IDLE);
    end
  end

  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign ack_a     = r_ack_a;
  assign ack_b     = r_ack_b;
  assign err_a     = r_err_a;
  assign err_b     = r_err_b;
  assign rdata_a   = r_rdata_a;
  assign rdata_b   = r_rdata_b;
  assign busy      = r_busy;

endmodule

// File: tb/tb_ram_port_rr_arbiter.sv
// Drives two arbiter instances (index 0: partitions enforced, index 1: open)
// with identical requester traffic; each has its own RAM model. Expectations
// come from a transaction-level model: winner choice, partition rule and a
// per-instance reference memory.
module tb_ram_port_rr_arbiter;

  localparam int DW    = 8;
  localparam int AW    = 11;
  localparam int PB    = 1024;
  localparam int DEPTH = 2048;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic          req_a = 1'b0, req_b = 1'b0, we_a = 1'b0, we_b = 1'b0;
  logic [AW-1:0] addr_a = '0, addr_b = '0;
  logic [DW-1:0] wdata_a = '0, wdata_b = '0;

  logic [1:0]         ack_a, ack_b, err_a, err_b, mem_en, mem_we, busy;
  logic [1:0][DW-1:0] rdata_a, rdata_b, mem_wdata, mem_rdata;
  logic [1:0][AW-1:0] mem_addr;

  ram_port_rr_arbiter #(.DATA_W(DW), .ADDR_W(AW), .PART_BOUNDARY(PB), .PROT_EN(1'b1)) u_dut_prot (
    .clk(clk), .reset_n(reset_n),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .ack_a(ack_a[0]), .ack_b(ack_b[0]), .err_a(err_a[0]), .err_b(err_b[0]),
    .rdata_a(rdata_a[0]), .rdata_b(rdata_b[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .busy(busy[0])
  );

  ram_port_rr_arbiter #(.DATA_W(DW), .ADDR_W(AW), .PART_BOUNDARY(PB), .PROT_EN(1'b0)) u_dut_open (
    .clk(clk), .reset_n(reset_n),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .ack_a(ack_a[1]), .ack_b(ack_b[1]), .err_a(err_a[1]), .err_b(err_b[1]),
    .rdata_a(rdata_a[1]), .rdata_b(rdata_b[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .busy(busy[1])
  );

  // Single-port RAM models, one-cycle read latency.
  for (genvar g = 0; g < 2; g++) begin : g_ram
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] q = '0;
    initial for (int k = 0; k < DEPTH; k++) mem[k] = '0;
    always @(posedge clk) begin
      if (mem_en[g]) begin
        if (mem_we[g]) mem[mem_addr[g]] <= mem_wdata[g];
        else           q <= mem[mem_addr[g]];
      end
    end
    assign mem_rdata[g] = q;
  end

  int            n_pass = 0;
  int            n_chk  = 0;
  int            cnt [2];
  logic          last_b = 1'b1;
  logic [DW-1:0] ref_mem [2][DEPTH];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int inst, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s[inst%0d]: got %0h expected %0h", tag, inst, got, exp);
  endtask

  task automatic issue(input int r, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (r == 0) begin req_a = 1'b1; we_a = we; addr_a = a; wdata_a = d; end
    else        begin req_b = 1'b1; we_b = we; addr_b = a; wdata_b = d; end
  endtask

  function automatic logic exp_err(input int inst, input int r, input logic [AW-1:0] a);
    if (inst == 1) return 1'b0;
    return (r == 0) ? (int'(a) >= PB) : (int'(a) < PB);
  endfunction

  function automatic logic [AW-1:0] pick_addr();
    case ($urandom_range(0, 5))
      0:       return 11'h000;
      1:       return 11'h3FF;
      2:       return 11'h400;
      3:       return 11'h7FF;
      4:       return 11'h005;
      default: return 11'($urandom_range(0, DEPTH - 1));
    endcase
  endfunction

  // One complete transaction starting in an IDLE cycle with at least one
  // request pending; ends in the following IDLE cycle with the winner's req dropped.
  task automatic do_txn();
    int            w;
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d, exp_rd;
    logic          e [2];
    if (req_a && req_b) w = last_b ? 0 : 1;
    else                w = req_a ? 0 : 1;
    we = (w == 1) ? we_b    : we_a;
    a  = (w == 1) ? addr_b  : addr_a;
    d  = (w == 1) ? wdata_b : wdata_a;
    for (int i = 0; i < 2; i++) e[i] = exp_err(i, w, a);

    tick();
    for (int i = 0; i < 2; i++) begin
      chk("acc_mem_en",    i, mem_en[i], !e[i]);
      chk("acc_mem_we",    i, mem_we[i], we && !e[i]);
      chk("acc_mem_addr",  i, mem_addr[i], a);
      chk("acc_mem_wdata", i, mem_wdata[i], d);
      chk("acc_busy",      i, busy[i], 1);
      chk("acc_ack",       i, {ack_b[i], ack_a[i]}, 0);
    end

    tick();
    for (int i = 0; i < 2; i++) begin
      chk("rdw_mem_en", i, {mem_en[i], mem_we[i]}, 0);
      chk("rdw_ack",    i, {ack_b[i], ack_a[i]}, 0);
      chk("rdw_busy",   i, busy[i], 1);
    end

    tick();
    for (int i = 0; i < 2; i++) begin
      exp_rd = (!we && !e[i]) ? ref_mem[i][a] : '0;
      chk("done_ack",     i, {ack_b[i], ack_a[i]}, (w == 1) ? 2'b10 : 2'b01);
      chk("done_err",     i, {err_b[i], err_a[i]}, !e[i] ? 2'b00 : ((w == 1) ? 2'b10 : 2'b01));
      chk("done_rdata_w", i, (w == 1) ? rdata_b[i] : rdata_a[i], exp_rd);
      chk("done_rdata_l", i, (w == 1) ? rdata_a[i] : rdata_b[i], 0);
      chk("done_mem_en",  i, mem_en[i], 0);
      chk("done_busy",    i, busy[i], 1);
      if (we && !e[i]) ref_mem[i][a] = d;
    end
    last_b = (w == 1);
    if (w == 0) req_a = 1'b0;
    else        req_b = 1'b0;

    tick();
    for (int i = 0; i < 2; i++) begin
      chk("idle_resp",  i, {ack_b[i], ack_a[i], err_b[i], err_a[i]}, 0);
      chk("idle_rdata", i, {rdata_b[i], rdata_a[i]}, 0);
      chk("idle_busy",  i, {busy[i], mem_en[i]}, 0);
    end
  endtask

  // B read interrupted by reset after `stage` edges (1 = ACCESS, 2 = RDWAIT).
  task automatic reset_mid(input int stage);
    issue(1, 1'b0, 11'h400, '0);
    for (int k = 0; k < stage; k++) tick();
    #1;
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_mem_en", i, mem_en[i], 0);
      chk("rst_ack_b",  i, ack_b[i], 0);
      chk("rst_busy",   i, busy[i], 0);
    end
    req_b = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    last_b = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      for (int i = 0; i < 2; i++)
        chk("post_rst_quiet", i, {ack_b[i], ack_a[i], busy[i], mem_en[i]}, 0);
    end
    issue(0, 1'b0, 11'h005, '0);
    issue(1, 1'b0, 11'h7FF, '0);
    do_txn();
    do_txn();
  endtask

  initial begin
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < DEPTH; k++) ref_mem[i][k] = '0;

    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("rst_strobes", i, {mem_en[i], mem_we[i], busy[i]}, 0);
      chk("rst_mem_bus", i, {mem_addr[i], mem_wdata[i]}, 0);
      chk("rst_resp",    i, {ack_b[i], ack_a[i], err_b[i], err_a[i]}, 0);
      chk("rst_rdata",   i, {rdata_b[i], rdata_a[i]}, 0);
    end
    reset_n = 1'b1;

    // Both requesters continuously pending from reset: four grants each.
    cnt[0] = 1;
    cnt[1] = 1;
    issue(0, 1'b1, 11'h010, 8'hA0);
    issue(1, 1'b1, 11'h410, 8'hB0);
    for (int k = 0; k < 8; k++) begin
      do_txn();
      if (last_b == 1'b0 && cnt[0] < 4) begin
        issue(0, 1'($urandom_range(0, 1)), 11'h010 + 11'(cnt[0] % 2), 8'($urandom));
        cnt[0]++;
      end else if (last_b == 1'b1 && cnt[1] < 4) begin
        issue(1, 1'($urandom_range(0, 1)), 11'h410 + 11'(cnt[1] % 2), 8'($urandom));
        cnt[1]++;
      end
    end

    // Directed accesses.
    issue(0, 1'b1, 11'h005, 8'h12); do_txn();
    issue(0, 1'b0, 11'h005, 8'h00); do_txn();
    issue(1, 1'b1, 11'h3FF, 8'h34); do_txn();
    issue(0, 1'b0, 11'h3FF, 8'h00); do_txn();
    issue(0, 1'b1, 11'h400, 8'h77); do_txn();
    issue(1, 1'b0, 11'h400, 8'h00); do_txn();
    issue(1, 1'b1, 11'h7FF, 8'h5A); do_txn();
    issue(1, 1'b0, 11'h7FF, 8'h00); do_txn();

    // Random traffic with boundary-heavy addresses.
    for (int it = 0; it < 80; it++) begin
      if (!req_a && $urandom_range(0, 1) == 1)
        issue(0, 1'($urandom_range(0, 1)), pick_addr(), 8'($urandom));
      if (!req_b && $urandom_range(0, 1) == 1)
        issue(1, 1'($urandom_range(0, 1)), pick_addr(), 8'($urandom));
      if (req_a || req_b) begin
        do_txn();
      end else begin
        tick();
        for (int i = 0; i < 2; i++)
          chk("rand_idle", i, {busy[i], mem_en[i], ack_b[i], ack_a[i]}, 0);
      end
    end
    for (int k = 0; k < 2 && (req_a || req_b); k++) do_txn();

    reset_mid(1);
    reset_mid(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
